// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the fetch and data ports.
// The optional single-entry fetch buffer is enabled by defining IFETCH_BUF_EN.
module unified_mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ifReq,
  input  logic [AW-1:0] PCF,
  output logic [DW-1:0] instrF,
  output logic          stallIF,
  input  logic          dReq,
  input  logic          memWriteM,
  input  logic [AW-1:0] ALUOutM,
  input  logic [DW-1:0] writeDataM,
  output logic [DW-1:0] readDataM,
  output logic          stallMem,
  output logic          memReq,
  output logic          memWe,
  output logic [AW-1:0] memAddr,
  output logic [DW-1:0] memWData,
  input  logic [DW-1:0] memRData,
  input  logic          memAck,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IBUSY = 3'd1,
    DBUSY = 3'd2,
    IDONE = 3'd3,
    DDONE = 3'd4
  } state_t;

  // Abort fires at the end of the MAX_WAIT-th BUSY cycle without an ack.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic       grant_i, grant_d, finish, abort;
  logic       fetch_hit;

`ifdef IFETCH_BUF_EN
  logic [AW-1:0] tag;
  logic          tag_valid;

  assign fetch_hit = tag_valid && (PCF == tag);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag       <= '0;
      tag_valid <= 1'b0;
    end else if (state == IBUSY && memAck) begin
      tag       <= memAddr;
      tag_valid <= 1'b1;
    end else if (abort) begin
      tag_valid <= 1'b0;
    end else if (state == DBUSY && memWe && memAddr == tag) begin
      tag_valid <= 1'b0;
    end
  end
`else
  assign fetch_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (dReq) begin
          state_next = DBUSY;
          grant_d    = 1'b1;
        end else if (ifReq) begin
          state_next = fetch_hit ? IDONE : IBUSY;
          grant_i    = !fetch_hit;
        end
      end
      IBUSY, DBUSY: begin
        if (memAck) begin
          finish = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          finish = 1'b1;
          abort  = 1'b1;
        end
        if (finish) state_next = (state == IBUSY) ? IDONE : DDONE;
      end
      IDONE, DDONE: state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWData  <= '0;
      instrF    <= '0;
      readDataM <= '0;
      err       <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state <= state_next;
      if (grant_d) begin
        memReq   <= 1'b1;
        memWe    <= memWriteM;
        memAddr  <= ALUOutM;
        memWData <= writeDataM;
      end else if (grant_i) begin
        memReq  <= 1'b1;
        memWe   <= 1'b0;
        memAddr <= PCF;
      end else if (finish) begin
        memReq <= 1'b0;
        memWe  <= 1'b0;
      end

      if (state == IBUSY || state == DBUSY) wait_cnt <= wait_cnt + 8'd1;
      else                                  wait_cnt <= '0;

      if (abort) err <= 1'b1;

      if (state == IBUSY && finish) instrF <= abort ? '0 : memRData;
      if (state == DBUSY && finish && !memWe) readDataM <= abort ? '0 : memRData;
    end
  end

  assign stallIF  = ifReq & (state != IDONE);
  assign stallMem = dReq & (state != DDONE);

endmodule
